// File: rtl/vram_pkg.sv
// Shared defaults and requester-id type for the VRAM port-B arbiter slice.
package vram_pkg;

    localparam int unsigned AW_DEF     = 12;
    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned RD_LAT_DEF = 2;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Valid/requester-id shift pipeline; a pushed read tag appears at the output DEPTH cycles later.
module vram_rd_tag_pipe
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LAT_DEF + 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  req_id_e push_id,
    output logic    out_valid,
    output req_id_e out_id
);

    logic [DEPTH-1:0] vld_q;
    req_id_e          id_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i] <= REQ0;
            end
        end else begin
            vld_q   <= {vld_q[DEPTH-2:0], push};
            id_q[0] <= push_id;
            for (int i = 1; i < DEPTH; i++) begin
                id_q[i] <= id_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Two-requester round-robin arbiter onto a single registered VRAM port B with read-return routing.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          r0_valid,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ready,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_valid,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ready,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

    output logic [AW-1:0] addr_b,
    output logic [DW-1:0] data_b,
    output logic          we_b,
    input  logic [DW-1:0] q_b
);

    logic          gnt0, gnt1, xfer;
    req_id_e       sel, last_q;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr, addr_q;
    logic [DW-1:0] cmd_wdata, data_q;
    logic          we_q;
    logic          tag_valid;
    req_id_e       tag_id;

    // Held in reset, nobody is granted; on contention the most recent winner yields.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (r0_valid && r1_valid) begin
                gnt0 = (last_q == REQ1);
                gnt1 = (last_q == REQ0);
            end else begin
                gnt0 = r0_valid;
                gnt1 = r1_valid;
            end
        end
    end

    always_comb begin
        xfer      = gnt0 | gnt1;
        sel       = gnt1 ? REQ1 : REQ0;
        cmd_we    = gnt1 ? r1_we    : r0_we;
        cmd_addr  = gnt1 ? r1_addr  : r0_addr;
        cmd_wdata = gnt1 ? r1_wdata : r0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ1;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= xfer && cmd_we;
            if (xfer) begin
                last_q <= sel;
                addr_q <= cmd_addr;
            end
            // Reads leave the write-data register untouched.
            if (xfer && cmd_we) begin
                data_q <= cmd_wdata;
            end
        end
    end

    vram_rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (xfer && !cmd_we),
        .push_id   (sel),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    assign r0_ready  = gnt0;
    assign r1_ready  = gnt1;
    assign addr_b    = addr_q;
    assign data_b    = data_q;
    assign we_b      = we_q;
    assign r0_rvalid = tag_valid && (tag_id == REQ0);
    assign r1_rvalid = tag_valid && (tag_id == REQ1);
    assign r0_rdata  = q_b;
    assign r1_rdata  = q_b;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised scoreboard bench for vram_port_arbiter against an abstract memory/round-robin model.
module tb_vram_port_arbiter;
    import vram_pkg::*;

    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r0_we, r0_ready, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_we, r1_ready, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;
    logic          we_b;
    logic [DW-1:0] q_b;

    vram_port_arbiter #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ready  (r0_ready),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_valid  (r1_valid),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ready  (r1_ready),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .addr_b    (addr_b),
        .data_b    (data_b),
        .we_b      (we_b),
        .q_b       (q_b)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endfunction

    // Port-B VRAM: read-before-write, data appears RD_LAT cycles after the address.
    logic [DW-1:0] vram [0:(1<<AW)-1];
    logic [DW-1:0] dl   [RD_LAT];
    always @(posedge clk) begin
        dl[0] <= vram[addr_b];
        for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
        if (we_b === 1'b1) vram[addr_b] <= data_b;
    end
    assign q_b = dl[RD_LAT-1];

    typedef struct {
        int unsigned   due;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pb_t;
    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } rd_t;

    pb_t pb_q[$];
    rd_t rd_q0[$];
    rd_t rd_q1[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            last_win = 1;

    // Reference model: decides the winner from the round-robin rule, predicts port-B and read returns.
    always @(negedge clk) begin
        logic          g0, g1, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!rst_n) begin
            chk("ready0_in_reset", r0_ready, 0);
            chk("ready1_in_reset", r1_ready, 0);
            pb_q.delete();
            rd_q0.delete();
            rd_q1.delete();
            last_win = 1;
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
            if (r0_valid && r1_valid) begin
                if (last_win == 1) g0 = 1'b1;
                else g1 = 1'b1;
            end else begin
                g0 = r0_valid;
                g1 = r1_valid;
            end
            chk("ready0", r0_ready, g0);
            chk("ready1", r1_ready, g1);
            if (g0 || g1) begin
                we = g1 ? r1_we : r0_we;
                a  = g1 ? r1_addr : r0_addr;
                d  = g1 ? r1_wdata : r0_wdata;
                pb_q.push_back('{cyc + 1, we, a, d});
                if (we) ref_mem[a] = d;
                else if (g1) rd_q1.push_back('{cyc + RD_LAT + 1, ref_mem[a]});
                else rd_q0.push_back('{cyc + RD_LAT + 1, ref_mem[a]});
                last_win = g1 ? 1 : 0;
            end
        end
    end

    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;

    // Monitor: pops port-B and read-return expectations when they fall due.
    always @(negedge clk) begin
        pb_t e;
        rd_t r;
        if (!rst_n) begin
            chk("we_b_in_reset", we_b, 0);
            chk("addr_b_in_reset", addr_b, 0);
            chk("data_b_in_reset", data_b, 0);
            chk("rvalid0_in_reset", r0_rvalid, 0);
            chk("rvalid1_in_reset", r1_rvalid, 0);
            exp_addr = '0;
            exp_data = '0;
        end else begin
            if (pb_q.size() > 0 && pb_q[0].due == cyc) begin
                e = pb_q.pop_front();
                chk("we_b", we_b, e.we);
                exp_addr = e.addr;
                if (e.we) exp_data = e.data;
            end else begin
                chk("we_b_idle", we_b, 0);
            end
            chk("addr_b", addr_b, exp_addr);
            chk("data_b", data_b, exp_data);
            if (rd_q0.size() > 0 && rd_q0[0].due == cyc) begin
                r = rd_q0.pop_front();
                chk("rvalid0", r0_rvalid, 1);
                chk("rdata0", r0_rdata, r.data);
            end else begin
                chk("rvalid0_idle", r0_rvalid, 0);
            end
            if (rd_q1.size() > 0 && rd_q1[0].due == cyc) begin
                r = rd_q1.pop_front();
                chk("rvalid1", r1_rvalid, 1);
                chk("rdata1", r1_rdata, r.data);
            end else begin
                chk("rvalid1_idle", r1_rvalid, 0);
            end
        end
    end

    task automatic cmd(input logic v0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    endtask

    task automatic idle(input int n);
        repeat (n) cmd(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // One full cycle of reset with both valids high to exercise ready gating.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i]    = '0;
            ref_mem[i] = '0;
        end
        rst_n = 1'b1;
        r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        #2 rst_n = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // Single write from r0.
        cmd(1, 1, 12'h005, 32'h44E94E80, 0, 0, '0, '0);
        idle(3);

        // Contention straight after reset: r0 first, then alternating.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cmd(1, 1, 12'h020 + 12'(i), 32'h1000 + 32'(i), 1, 1, 12'h030 + 12'(i),
                32'h2000 + 32'(i));
        end
        idle(2);

        // Back-to-back reads from r1 of preloaded words.
        cmd(1, 1, 12'h010, 32'hA0, 0, 0, '0, '0);
        cmd(1, 1, 12'h011, 32'hA1, 0, 0, '0, '0);
        cmd(0, 0, '0, '0, 1, 0, 12'h010, '0);
        cmd(0, 0, '0, '0, 1, 0, 12'h011, '0);
        idle(6);

        // Write then immediate read of the same word by the other requester.
        cmd(1, 1, 12'h123, 32'hDEADBEEF, 0, 0, '0, '0);
        cmd(0, 0, '0, '0, 1, 0, 12'h123, '0);
        idle(5);

        // Read in flight across a reset pulse must never return.
        cmd(1, 0, 12'h010, '0, 0, 0, '0, '0);
        do_reset();
        idle(5);

        // Lone requester streams without stalls.
        for (int i = 0; i < 3; i++) cmd(0, 0, '0, '0, 1, 0, 12'h040 + 12'(i), '0);
        idle(5);

        // Random mixed traffic over a small address window to force hazards.
        for (int i = 0; i < 600; i++) begin
            cmd(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                $urandom, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                12'($urandom_range(0, 15)), $urandom);
        end
        idle(10);

        chk("pending_portb", pb_q.size(), 0);
        chk("pending_rd0", rd_q0.size(), 0);
        chk("pending_rd1", rd_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 Parameter AW, default 12, SHALL set the VRAM word-address width.
REQ-002 Parameter DW, default 32, SHALL set the VRAM data width.
REQ-003 Parameter RD_LAT, default 2, legal range 1..4, SHALL set the cycles from addr_b presented to q_b valid.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 Ports, one per line:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 command valid
- r0_we  in  1  1 = write, 0 = read
- r0_addr  in  AW  word address
- r0_wdata  in  DW  write data
- r0_ready  out  1  command accepted this cycle
- r0_rvalid  out  1  read data valid
- r0_rdata  out  DW  read data
- r1_*  same set as r0_*, for requester 1
- addr_b  out  AW  VRAM port-B address
- data_b  out  DW  VRAM port-B write data
- we_b  out  1  VRAM port-B write enable
- q_b  in  DW  VRAM port-B read data

Function
REQ-006 A command SHALL transfer only on a cycle where rN_valid and rN_ready are both 1.
REQ-007 At most one rN_ready SHALL be 1 per cycle; rN_ready SHALL be 1 only when rN_valid is 1.
REQ-008 rN_ready SHALL be combinational from the valids and the round-robin pointer; no wait state.
REQ-009 Exactly one valid requester SHALL be granted on that cycle.
REQ-010 Both valid: the requester not granted most recently SHALL win; the pointer updates only on a transfer.
REQ-011 After reset, with both valid, requester 0 SHALL win first.
REQ-012 addr_b, data_b and we_b SHALL be registered and present the accepted command one cycle after transfer.
REQ-013 Write transfer: we_b = 1 for exactly one cycle, with the given address and data.
REQ-014 Read transfer: we_b = 0, addr_b = address; data_b SHALL hold its previous value.
REQ-015 Cycle with no transfer: we_b = 0; addr_b and data_b SHALL hold their previous values.
REQ-016 Each read SHALL be tagged with its requester id in an RD_LAT+1-deep valid/id pipeline.
REQ-017 rN_rvalid SHALL pulse for one cycle exactly RD_LAT+1 cycles after the read transfer, only for the owning requester.
REQ-018 rN_rdata SHALL equal q_b on that cycle; rdata is don't-care otherwise.
REQ-019 Back-to-back reads (one per cycle, either requester, mixed) SHALL return in issue order with no loss or stall.
REQ-020 Writes SHALL NOT generate rvalid.
REQ-021 A write followed by a read to the same address SHALL return the new data; ordering is preserved because port B is serialised.
REQ-022 Address arithmetic SHALL NOT occur in this block; addresses pass through unmodified, no wrap logic.
REQ-023 Throughput SHALL be one command per cycle sustained.

Reset
REQ-024 On rst_n low, asynchronously: we_b = 0, addr_b = 0, data_b = 0, both rvalid = 0, tag pipeline cleared, pointer set to prefer requester 0.
REQ-025 Reads in flight at reset SHALL be discarded; no rvalid SHALL follow reset release for them.
REQ-026 While rst_n is low, both rN_ready SHALL be 0.

Structure
REQ-027 A shared package vram_pkg SHALL hold the AW/DW/RD_LAT defaults and the requester-id type (1 bit, REQ0 = 0, REQ1 = 1).
REQ-028 The read-tag shift pipeline SHALL be a sub-module named vram_rd_tag_pipe (inputs: push, id; outputs: valid, id at depth RD_LAT+1).

Verification
REQ-029 r0 write addr 0x005, data 0x44E94E80 -> r0_ready = 1; next cycle we_b = 1, addr_b = 0x005, data_b = 0x44E94E80; following cycle we_b = 0.
REQ-030 Both valid for 4 cycles from reset, all writes -> grants r0, r1, r0, r1; addr_b sequence follows one cycle later.
REQ-031 r1 reads 0x010 then 0x011 back-to-back, RD_LAT = 2, q_b model returns 0xA0, 0xA1 -> r1_rvalid high on cycles +3 and +4 with those values; r0_rvalid stays 0.
REQ-032 r0 write 0x123 = 0xDEADBEEF, then r1 read 0x123 on the next cycle -> r1_rdata = 0xDEADBEEF.
REQ-033 Issue r0 read, assert rst_n low for 1 cycle before data returns, then release -> no rvalid; we_b = 0, addr_b = 0, data_b = 0 during reset.
REQ-034 Only r1 valid continuously for 3 cycles -> r1_ready = 1 every cycle, r0_ready = 0 throughout.
